// File: rtl/out_merge_sched_pkg.sv
// Shared types and constants for the ordered output merge scheduler.
// Holds the FSM state encoding, the error cause codes and the default index width.
package out_merge_sched_pkg;

  localparam int IDX_W_DEFAULT = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB,
    ST_XFER_V,
    ST_XFER_R,
    ST_DONE,
    ST_ERR
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_BOTH    = 2'b01;
  localparam logic [1:0] ERR_IDX     = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

endpackage

// File: rtl/out_merge_sched.sv
// Merges the varint and raw-data byte streams into the output FIFO in strict
// ascending record-index order, one whole record at a time, flagging order errors and stalls.
module out_merge_sched
  import out_merge_sched_pkg::*;
#(
  parameter int IDX_W   = IDX_W_DEFAULT,
  parameter int CNT_W   = 11,
  parameter int TIMEOUT = 1024
) (
  input  logic             clock_clk,
  input  logic             reset_reset,
  input  logic             start,
  input  logic [IDX_W-1:0] base_index,
  input  logic [CNT_W-1:0] rec_count,
  input  logic             abort,
  input  logic             varint_valid,
  input  logic [IDX_W-1:0] varint_index,
  input  logic [7:0]       varint_data,
  input  logic             varint_last,
  output logic             varint_accepted,
  input  logic             raw_valid,
  input  logic [IDX_W-1:0] raw_index,
  input  logic [7:0]       raw_data,
  input  logic             raw_last,
  output logic             raw_accepted,
  input  logic             out_fifo_full,
  output logic             out_fifo_push,
  output logic [7:0]       out_fifo_data,
  output logic             out_fifo_clr,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [1:0]       err_code
);

  localparam int STALL_W = $clog2(TIMEOUT) + 1;
  localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   expIdx_q, expIdx_d;
  logic [CNT_W-1:0]   recLeft_q, recLeft_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic               clr_q, clr_d;
  logic               done_q, done_d;
  logic [1:0]         errCode_q, errCode_d;

  logic       vMatch, rMatch;
  logic       selValid, selIdxOk, selLast, selFire;
  logic [7:0] selData;

  assign vMatch = varint_valid && (varint_index == expIdx_q);
  assign rMatch = raw_valid && (raw_index == expIdx_q);

  // The transfer state that owns a record steers that source onto one set of head signals.
  always_comb begin
    selValid = 1'b0;
    selIdxOk = 1'b0;
    selLast  = 1'b0;
    selData  = 8'h00;
    if (state_q == ST_XFER_V) begin
      selValid = varint_valid;
      selIdxOk = (varint_index == expIdx_q);
      selLast  = varint_last;
      selData  = varint_data;
    end else if (state_q == ST_XFER_R) begin
      selValid = raw_valid;
      selIdxOk = (raw_index == expIdx_q);
      selLast  = raw_last;
      selData  = raw_data;
    end
  end

  // Abort and reset both suppress the pop so no byte is lost into a discarded job.
  assign selFire = selValid && selIdxOk && !out_fifo_full && !abort && !reset_reset;

  always_comb begin
    state_d   = state_q;
    expIdx_d  = expIdx_q;
    recLeft_d = recLeft_q;
    stall_d   = '0;
    clr_d     = 1'b0;
    done_d    = 1'b0;
    errCode_d = errCode_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          expIdx_d  = base_index;
          recLeft_d = rec_count;
          clr_d     = 1'b1;
          errCode_d = ERR_NONE;
          if (rec_count == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_ARB;
          end
        end
      end
      ST_ARB: begin
        if (vMatch && rMatch) begin
          state_d   = ST_ERR;
          errCode_d = ERR_BOTH;
        end else if (vMatch) begin
          state_d = ST_XFER_V;
        end else if (rMatch) begin
          state_d = ST_XFER_R;
        end else if (stall_q == STALL_MAX) begin
          state_d   = ST_ERR;
          errCode_d = ERR_TIMEOUT;
        end else begin
          stall_d = stall_q + STALL_W'(1);
        end
      end
      ST_XFER_V, ST_XFER_R: begin
        if (selValid && !selIdxOk) begin
          state_d   = ST_ERR;
          errCode_d = ERR_IDX;
        end else if (selFire && selLast) begin
          expIdx_d  = expIdx_q + IDX_W'(1);
          recLeft_d = recLeft_q - CNT_W'(1);
          if (recLeft_q == CNT_W'(1)) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_ARB;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort) begin
      state_d   = ST_IDLE;
      expIdx_d  = expIdx_q;
      recLeft_d = recLeft_q;
      stall_d   = '0;
      clr_d     = 1'b0;
      done_d    = 1'b0;
      errCode_d = ERR_NONE;
    end
  end

  always_ff @(posedge clock_clk) begin
    if (reset_reset) begin
      state_q   <= ST_IDLE;
      expIdx_q  <= '0;
      recLeft_q <= '0;
      stall_q   <= '0;
      clr_q     <= 1'b0;
      done_q    <= 1'b0;
      errCode_q <= ERR_NONE;
    end else begin
      state_q   <= state_d;
      expIdx_q  <= expIdx_d;
      recLeft_q <= recLeft_d;
      stall_q   <= stall_d;
      clr_q     <= clr_d;
      done_q    <= done_d;
      errCode_q <= errCode_d;
    end
  end

  assign varint_accepted = selFire && (state_q == ST_XFER_V);
  assign raw_accepted    = selFire && (state_q == ST_XFER_R);
  assign out_fifo_push   = selFire;
  assign out_fifo_data   = selFire ? selData : 8'h00;
  assign out_fifo_clr    = clr_q;
  assign busy            = (state_q == ST_ARB) || (state_q == ST_XFER_V) || (state_q == ST_XFER_R);
  assign done            = done_q;
  assign err             = (state_q == ST_ERR);
  assign err_code        = errCode_q;

endmodule

// File: tb/tb_out_merge_sched.sv
// Scoreboard bench for out_merge_sched: records are generated per index, the expected
// byte stream is the records concatenated in ascending index order, and a monitor pops it.
module tb_out_merge_sched;

  typedef struct packed {
    logic [9:0] idx;
    logic [7:0] data;
    logic       last;
  } beat_t;

  logic        clock_clk;
  logic        reset_reset;
  logic        start;
  logic [9:0]  base_index;
  logic [10:0] rec_count;
  logic        abort;
  logic        varint_valid;
  logic [9:0]  varint_index;
  logic [7:0]  varint_data;
  logic        varint_last;
  logic        varint_accepted;
  logic        raw_valid;
  logic [9:0]  raw_index;
  logic [7:0]  raw_data;
  logic        raw_last;
  logic        raw_accepted;
  logic        out_fifo_full;
  logic        out_fifo_push;
  logic [7:0]  out_fifo_data;
  logic        out_fifo_clr;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  err_code;

  beat_t      vQ[$];
  beat_t      rQ[$];
  logic [7:0] expQ[$];

  int errors    = 0;
  int checks    = 0;
  int doneCount = 0;
  int fullMode  = 0;
  bit gapEn     = 0;

  out_merge_sched #(.IDX_W(10), .CNT_W(11), .TIMEOUT(16)) dut (
    .clock_clk(clock_clk), .reset_reset(reset_reset), .start(start),
    .base_index(base_index), .rec_count(rec_count), .abort(abort),
    .varint_valid(varint_valid), .varint_index(varint_index), .varint_data(varint_data),
    .varint_last(varint_last), .varint_accepted(varint_accepted),
    .raw_valid(raw_valid), .raw_index(raw_index), .raw_data(raw_data),
    .raw_last(raw_last), .raw_accepted(raw_accepted),
    .out_fifo_full(out_fifo_full), .out_fifo_push(out_fifo_push),
    .out_fifo_data(out_fifo_data), .out_fifo_clr(out_fifo_clr),
    .busy(busy), .done(done), .err(err), .err_code(err_code)
  );

  initial clock_clk = 1'b0;
  always #5 clock_clk = ~clock_clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Queues one record on a source; when expected it also joins the reference output stream.
  task automatic addRecord(input bit toRaw, input int idx, input int len, input bit closeLast, input bit expected);
    for (int i = 0; i < len; i++) begin
      beat_t b;
      b.idx  = 10'(idx);
      b.data = 8'($urandom);
      b.last = (i == len - 1) && closeLast;
      if (toRaw) rQ.push_back(b);
      else vQ.push_back(b);
      if (expected) expQ.push_back(b.data);
    end
  endtask

  task automatic applyStimulus(input int base, input int count);
    @(posedge clock_clk); #1;
    base_index = 10'(base);
    rec_count  = 11'(count);
    start      = 1'b1;
    @(posedge clock_clk); #1;
    start = 1'b0;
  endtask

  task automatic waitEvent(input int maxCycles, output int cycles, output bit hit);
    cycles = 0;
    hit    = 1'b0;
    while (!hit && cycles < maxCycles) begin
      @(negedge clock_clk);
      cycles++;
      if (done || err) hit = 1'b1;
    end
    #1;
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, " busy"}, 32'(busy), 0);
    checkOutput({tag, " done"}, 32'(done), 0);
    checkOutput({tag, " err"}, 32'(err), 0);
    checkOutput({tag, " err_code"}, 32'(err_code), 0);
    checkOutput({tag, " push"}, 32'(out_fifo_push), 0);
    checkOutput({tag, " clr"}, 32'(out_fifo_clr), 0);
    checkOutput({tag, " accepts"}, 32'({varint_accepted, raw_accepted}), 0);
    checkOutput({tag, " data"}, 32'(out_fifo_data), 0);
  endtask

  // Source and FIFO-full driver: pops a head beat on the edge after it was accepted.
  initial begin
    bit vTake, rTake;
    varint_valid = 0; varint_index = 0; varint_data = 0; varint_last = 0;
    raw_valid = 0; raw_index = 0; raw_data = 0; raw_last = 0;
    out_fifo_full = 0;
    forever begin
      @(negedge clock_clk);
      vTake = varint_accepted;
      rTake = raw_accepted;
      @(posedge clock_clk); #1;
      if (vTake && vQ.size() > 0) void'(vQ.pop_front());
      if (rTake && rQ.size() > 0) void'(rQ.pop_front());
      if (vQ.size() > 0 && !(gapEn && $urandom_range(0, 3) == 0)) begin
        varint_valid = 1'b1;
        {varint_index, varint_data, varint_last} = vQ[0];
      end else varint_valid = 1'b0;
      if (rQ.size() > 0 && !(gapEn && $urandom_range(0, 3) == 0)) begin
        raw_valid = 1'b1;
        {raw_index, raw_data, raw_last} = rQ[0];
      end else raw_valid = 1'b0;
      case (fullMode)
        1: out_fifo_full = ($urandom_range(0, 2) == 0);
        2: out_fifo_full = !out_fifo_full;
        default: out_fifo_full = 1'b0;
      endcase
    end
  end

  // Monitor: every push must be the next byte of the reference stream.
  initial begin
    forever begin
      @(negedge clock_clk);
      if (!reset_reset) begin
        if (out_fifo_full) checkOutput("push while full", 32'(out_fifo_push), 0);
        if (out_fifo_push) begin
          checkOutput("single source accept", 32'(varint_accepted ^ raw_accepted), 1);
          if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected push: got %0h expected none", out_fifo_data);
          end else checkOutput("push data", 32'(out_fifo_data), 32'(expQ.pop_front()));
        end else checkOutput("accept without push", 32'(varint_accepted | raw_accepted), 0);
        if (done) doneCount++;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int cyc, d0;
    bit hit;
    reset_reset = 1'b1; start = 1'b0; abort = 1'b0; base_index = '0; rec_count = '0;
    repeat (3) @(posedge clock_clk);
    #1 reset_reset = 1'b0;
    @(negedge clock_clk);
    checkIdleOutputs("after reset");

    $display("[TB] directed: base 5 count 3");
    addRecord(0, 5, 2, 1, 1);
    addRecord(1, 6, 3, 1, 1);
    addRecord(0, 7, 1, 1, 1);
    d0 = doneCount;
    applyStimulus(5, 3);
    @(negedge clock_clk);
    checkOutput("start clr", 32'(out_fifo_clr), 1);
    checkOutput("start busy", 32'(busy), 1);
    waitEvent(100, cyc, hit);
    checkOutput("job1 finished", 32'(hit), 1);
    checkOutput("job1 latency", 32'(cyc), 9);
    checkOutput("job1 err", 32'(err), 0);
    checkOutput("job1 busy at done", 32'(busy), 0);
    checkOutput("job1 done count", 32'(doneCount - d0), 1);
    checkOutput("job1 bytes left", 32'(expQ.size()), 0);

    $display("[TB] directed: index wrap");
    addRecord(1, 1023, 2, 1, 1);
    addRecord(0, 0, 1, 1, 1);
    d0 = doneCount;
    applyStimulus(1023, 2);
    waitEvent(100, cyc, hit);
    checkOutput("wrap finished", 32'(hit), 1);
    checkOutput("wrap err", 32'(err), 0);
    checkOutput("wrap done count", 32'(doneCount - d0), 1);
    checkOutput("wrap bytes left", 32'(expQ.size()), 0);

    $display("[TB] directed: both sources match");
    addRecord(0, 10, 1, 1, 0);
    addRecord(1, 10, 1, 1, 0);
    applyStimulus(10, 1);
    waitEvent(50, cyc, hit);
    checkOutput("both err", 32'(err), 1);
    checkOutput("both code", 32'(err_code), 1);
    vQ.delete(); rQ.delete();

    $display("[TB] directed: index change mid-record");
    addRecord(0, 4, 2, 0, 1);
    addRecord(0, 9, 1, 1, 0);
    applyStimulus(4, 2);
    waitEvent(50, cyc, hit);
    checkOutput("idx err", 32'(err), 1);
    checkOutput("idx code", 32'(err_code), 2);
    checkOutput("idx bytes left", 32'(expQ.size()), 0);
    vQ.delete(); rQ.delete();

    $display("[TB] directed: stall timeout");
    applyStimulus(100, 1);
    @(negedge clock_clk);
    checkOutput("timeout busy", 32'(busy), 1);
    waitEvent(100, cyc, hit);
    checkOutput("timeout cycles", 32'(cyc), 16);
    checkOutput("timeout err", 32'(err), 1);
    checkOutput("timeout code", 32'(err_code), 3);
    d0 = doneCount;
    applyStimulus(0, 0);
    @(negedge clock_clk);
    checkOutput("restart err", 32'(err), 0);
    checkOutput("restart code", 32'(err_code), 0);
    checkOutput("restart clr", 32'(out_fifo_clr), 1);
    checkOutput("zero count done", 32'(done), 1);
    checkOutput("zero count busy", 32'(busy), 0);

    $display("[TB] directed: backpressure");
    fullMode = 2;
    addRecord(1, 20, 4, 1, 1);
    d0 = doneCount;
    applyStimulus(20, 1);
    waitEvent(100, cyc, hit);
    checkOutput("bp finished", 32'(hit), 1);
    checkOutput("bp err", 32'(err), 0);
    checkOutput("bp bytes left", 32'(expQ.size()), 0);
    fullMode = 0;

    $display("[TB] directed: reset mid-record");
    addRecord(0, 30, 6, 1, 1);
    applyStimulus(30, 1);
    @(negedge clock_clk);
    @(negedge clock_clk);
    @(posedge clock_clk); #1;
    reset_reset = 1'b1;
    @(negedge clock_clk);
    checkOutput("reset cycle push", 32'(out_fifo_push), 0);
    checkOutput("reset cycle accept", 32'(varint_accepted), 0);
    @(posedge clock_clk); #1;
    reset_reset = 1'b0;
    vQ.delete(); rQ.delete(); expQ.delete();
    @(negedge clock_clk);
    checkIdleOutputs("after mid reset");

    $display("[TB] directed: abort beats start");
    addRecord(0, 40, 1, 1, 0);
    applyStimulus(41, 1);
    abort = 1'b1; start = 1'b1;
    @(posedge clock_clk); #1;
    abort = 1'b0; start = 1'b0;
    @(negedge clock_clk);
    checkOutput("abort busy", 32'(busy), 0);
    checkOutput("abort clr", 32'(out_fifo_clr), 0);
    vQ.delete(); rQ.delete();

    $display("[TB] random jobs");
    gapEn = 1; fullMode = 1;
    for (int j = 0; j < 25; j++) begin
      int base, cnt;
      base = $urandom_range(0, 1023);
      cnt  = $urandom_range(1, 6);
      for (int k = 0; k < cnt; k++)
        addRecord(1'($urandom_range(0, 1)), (base + k) % 1024, $urandom_range(1, 4), 1, 1);
      d0 = doneCount;
      applyStimulus(base, cnt);
      waitEvent(500, cyc, hit);
      checkOutput("rand finished", 32'(hit), 1);
      checkOutput("rand err", 32'(err), 0);
      checkOutput("rand done count", 32'(doneCount - d0), 1);
      checkOutput("rand bytes left", 32'(expQ.size()), 0);
      vQ.delete(); rQ.delete(); expQ.delete();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
